ctrl_pipe: RTL
==============

# ctrl_pipe

Parametrised, multi-stage control-signal pipeline register with per-stage valid bits, stall back-pressure with bubble collapsing, and synchronous flush. It carries packed control fields (memory read/write, size, sign-extension and similar) from execute toward memory and writeback. It generalises the single-stage stall/flush control register to arbitrary payload width and stage count. Invalid stages present an all-zero payload, so downstream units never see a spurious memory command.

## Interface
- WIDTH, 2: payload width in bits (packed control fields); ≥1
- DEPTH, 1: number of register stages; ≥1
- ZERO_INVALID, 1: when 1, payload of an invalid stage is driven to zero; when 0, stale payload is held and only the valid bit is cleared
- clk  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high; clears all stages
- flush  in  1  synchronous kill of every stage and of the current input
- stall  in  1  downstream cannot accept the last stage this cycle
- in_valid  in  1  input payload is a real instruction
- in_data  in  WIDTH  input control payload
- in_ready  out  1  stage 0 will capture input this cycle (combinational)
- out_valid  out  1  last stage holds a real instruction
- out_data  out  WIDTH  last-stage payload
- occupancy  out  $clog2(DEPTH+1)  number of valid stages

## Operation
- Per stage i: registers v[i] and d[i].
- Advance rule: adv[DEPTH-1] = !stall || !v[DEPTH-1]; adv[i] = !v[i] || adv[i+1] for i < DEPTH-1.
- Bubble collapsing: an empty stage always accepts, even when stall is high, so stall propagates upstream only through contiguous full stages.
- On adv[i]: stage i loads from stage i-1 (stage 0 loads in_valid/in_data). When the source is invalid, v[i] ← 0 and d[i] ← 0 if ZERO_INVALID.
- When !adv[i]: stage i holds v[i] and d[i].
- in_ready = adv[0]. Upstream must hold in_data and in_valid while in_ready is low.
- Priority, highest first: reset, flush, advance/hold.
  - reset or flush: all v ← 0, all d ← 0, regardless of stall and in_valid. The input presented in the same cycle is discarded.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1]. Both are registered outputs with no combinational path from inputs.
- occupancy = popcount(v), registered, updated in the same edge as v.
- DEPTH=1, ZERO_INVALID=1, stall=~in_ready_upstream: behaviour is cycle-identical to the single-stage stall/flush control register.

## Timing
- Reset values: out_valid=0, out_data=0, occupancy=0. in_ready=1 after reset.
- Latency: DEPTH cycles from in_valid sampled with in_ready=1 to out_valid, when no stall occurs.
- Throughput: one item per cycle while stall=0.
- Full pipe + stall=1: in_ready=0 in the same cycle; contents are frozen.
- Stall asserted with a bubble in stage k: stages 0..k advance in that cycle, closing the bubble. in_ready drops only once every stage is valid.
- Stall deasserted: the last stage drains on that edge and in_ready rises combinationally in the same cycle.
- flush and stall together: flush wins; the pipe is empty on the next cycle.
- reset asserted mid-operation: the pipe is empty on the next edge. No partial drain.
- occupancy never exceeds DEPTH. It changes by at most +1/-1 per cycle, except on flush/reset, where it goes to 0.

## Structure
- Shared package ctrl_pipe_pkg:
  - typedef mem_ctrl_t, packed struct of mem_read, mem_write, mem_size[1:0], mem_unsigned (WIDTH=5 users pass $bits(mem_ctrl_t))
  - localparam MEM_CTRL_NOP = '0
- Sub-module ctrl_pipe_stage: one v/d register pair with inputs adv, kill, src_valid and src_data. Instantiate it DEPTH times in a generate loop.
- The adv chain and occupancy logic live in the top module.

## Test plan
- Reset/idle, DEPTH=3, WIDTH=5: assert reset for 2 cycles with in_valid=1, in_data=5'h1F -> out_valid=0, out_data=0, occupancy=0, in_ready=1 on the first post-reset cycle.
- Streaming, DEPTH=3: push 0x01, 0x02, 0x03 on consecutive cycles with stall=0 -> out_data shows 0x01/0x02/0x03 on cycles 3/4/5 with out_valid=1; occupancy reaches 3.
- Bubble collapse, DEPTH=3: push 0x0A, idle one cycle, push 0x0B, then hold stall=1 -> 0x0B reaches stage 1 directly behind 0x0A. in_ready stays 1 until three items are resident, then drops. Releasing stall emits 0x0A on the next edge.
- Flush under stall, DEPTH=2: pipe full {0x04,0x08}, stall=1, flush=1 with in_valid=1, in_data=0x10 -> next cycle out_valid=0, out_data=0, occupancy=0; 0x10 never appears.
- ZERO_INVALID=0, DEPTH=1: push 0x06, then in_valid=0 -> out_valid=0 and out_data remains 0x06.
- Legacy equivalence, DEPTH=1, WIDTH=2: random mem_read/mem_write, stall and flush for 1000 cycles -> out_data matches a single-stage reference model on every cycle.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared control-payload types for the ctrl_pipe pipeline
package ctrl_pipe_pkg;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
  } mem_ctrl_t;
  localparam mem_ctrl_t MEM_CTRL_NOP = '0;
endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one valid/payload register pair of the control pipeline
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH        = 2,
  parameter bit ZERO_INVALID = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_adv,
  input  logic             i_kill,
  input  logic             i_src_valid,
  input  logic [WIDTH-1:0] i_src_data,
  output logic             o_v,
  output logic [WIDTH-1:0] o_d
);
  logic             r_v;
  logic [WIDTH-1:0] r_d;
  // clear on reset/kill, load from source on advance, otherwise hold
  always_ff @(posedge clk) begin
    if (reset || i_kill) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (i_adv) begin
      r_v <= i_src_valid;
      r_d <= i_src_valid ? i_src_data : (ZERO_INVALID ? '0 : r_d);
    end
  end
  assign o_v = r_v;
  assign o_d = r_d;
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: multi-stage control pipeline with bubble-collapsing stall and flush
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH        = 2,
  parameter int DEPTH        = 1,
  parameter bit ZERO_INVALID = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       stall,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_src_v;
  logic [DEPTH-1:0] w_v_nxt;
  logic [WIDTH-1:0] w_d     [DEPTH];
  logic [WIDTH-1:0] w_src_d [DEPTH];
  logic [OW-1:0]    w_occ_nxt;
  logic [OW-1:0]    r_occ;
  logic             w_acc;
  // stall ripples upstream only through a contiguous run of full stages
  always_comb begin
    w_acc = !stall || !w_v[DEPTH-1];
    w_adv[DEPTH-1] = w_acc;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_acc = !w_v[i] || w_acc;
      w_adv[i] = w_acc;
    end
  end
  // each stage sources from its predecessor; stage 0 sources from the input
  always_comb begin
    w_src_v = DEPTH'({w_v, in_valid});
    w_src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) w_src_d[i] = w_d[i-1];
  end
  // occupancy tracks the popcount of the valid bits they will hold after this edge
  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_v_nxt[i] = (reset || flush) ? 1'b0 : (w_adv[i] ? w_src_v[i] : w_v[i]);
      w_occ_nxt = w_occ_nxt + OW'(w_v_nxt[i]);
    end
  end
  // registered occupancy, updated on the same edge as the valid bits
  always_ff @(posedge clk) begin
    if (reset) r_occ <= '0;
    else r_occ <= w_occ_nxt;
  end
  genvar s;
  for (s = 0; s < DEPTH; s++) begin : g_stage
    ctrl_pipe_stage #(.WIDTH(WIDTH), .ZERO_INVALID(ZERO_INVALID)) u_stage (
      .clk        (clk),
      .reset      (reset),
      .i_adv      (w_adv[s]),
      .i_kill     (flush),
      .i_src_valid(w_src_v[s]),
      .i_src_data (w_src_d[s]),
      .o_v        (w_v[s]),
      .o_d        (w_d[s])
    );
  end
  assign in_ready  = w_adv[0];
  assign out_valid = w_v[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];
  assign occupancy = r_occ;
endmodule
